// File: rtl/lcd_fmt_pkg.sv
// ----------------------------------------------------------------------------
// lcd_fmt_pkg
//   Definitions shared by the LCD pixel formatter and the pixel unpacker so
//   that both sides agree on bit packing.
//
//   Contents:
//     PIX_W, BYTE_W   fixed pixel and byte widths
//     ACC_W, CNT_W    width of the unpacker bit buffer and its fill count
//     lcd_pixmode_t   packing mode (3-bit colour, 4-bit mono, 8-bit mono)
//     pix_bits_t      per-mode bits-per-pixel (w) and useful bits-per-byte (b)
//     pix_bits()      mode -> {w, b}
//     decode_mode()   LcdBW / LcdMono8 pins -> mode
//     byte_mask()     mask selecting the useful bits of a packed byte
//     format_pixel()  buffer LSBs -> 3-bit output pixel for a mode
// ----------------------------------------------------------------------------
package lcd_fmt_pkg;

  localparam int PIX_W  = 3;
  localparam int BYTE_W = 8;

  // The buffer must hold up to W-1 leftover bits plus one whole byte.
  localparam int ACC_W  = PIX_W - 1 + BYTE_W;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    MODE_COLOR3 = 2'd0,
    MODE_MONO4  = 2'd1,
    MODE_MONO8  = 2'd2
  } lcd_pixmode_t;

  typedef struct packed {
    logic [CNT_W-1:0] w;  // stream bits consumed per pixel
    logic [CNT_W-1:0] b;  // stream bits contributed per byte
  } pix_bits_t;

  function automatic pix_bits_t pix_bits(input lcd_pixmode_t mode);
    pix_bits_t r;
    r.w = (mode == MODE_COLOR3) ? CNT_W'(PIX_W) : CNT_W'(1);
    r.b = (mode == MODE_MONO4)  ? CNT_W'(4)     : CNT_W'(BYTE_W);
    return r;
  endfunction

  function automatic lcd_pixmode_t decode_mode(input logic bw, input logic mono8);
    lcd_pixmode_t m;
    if (!bw) begin
      m = MODE_COLOR3;
    end else if (mono8) begin
      m = MODE_MONO8;
    end else begin
      m = MODE_MONO4;
    end
    return m;
  endfunction

  // Only a 4-bit byte payload drops its upper nibble.
  function automatic logic [BYTE_W-1:0] byte_mask(input logic [CNT_W-1:0] b);
    return (b == CNT_W'(4)) ? 8'h0F : 8'hFF;
  endfunction

  // Mono pixels are replicated so the panel sees full black or full white;
  // the formatter only looks at bit 0, so a round trip is lossless.
  function automatic logic [PIX_W-1:0] format_pixel(input lcd_pixmode_t mode,
                                                    input logic [PIX_W-1:0] lsb);
    logic [PIX_W-1:0] p;
    if (mode == MODE_COLOR3) begin
      p = lsb;
    end else begin
      p = {PIX_W{lsb[0]}};
    end
    return p;
  endfunction

endpackage

// File: rtl/lcd_unpack_bitbuf.sv
// ----------------------------------------------------------------------------
// lcd_unpack_bitbuf
//   LSB-first bit buffer of the pixel unpacker. Holds acc (buffered stream
//   bits) and cnt (how many of them are live). Each cycle it optionally drops
//   one pixel (w bits) from the bottom and optionally merges a fresh byte
//   (b useful bits) directly above the bits that remain.
//
//   Ports:
//     clk      in   clock, rising edge
//     clear    in   synchronous clear of acc/cnt (reset or flush)
//     w        in   bits per pixel for the current mode
//     b        in   useful bits per byte for the current mode
//     xfer     in   a pixel leaves the buffer this cycle
//     read     in   the byte on datain enters the buffer this cycle
//     datain   in   FIFO head byte
//     pix_lsb  out  lowest PIX_W buffered bits (next pixel)
//     cnt      out  number of live bits in the buffer (0..10)
//     rem      out  bits left after this cycle's transfer
// ----------------------------------------------------------------------------
module lcd_unpack_bitbuf
  import lcd_fmt_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic [CNT_W-1:0]  w,
  input  logic [CNT_W-1:0]  b,
  input  logic              xfer,
  input  logic              read,
  input  logic [BYTE_W-1:0] datain,
  output logic [PIX_W-1:0]  pix_lsb,
  output logic [CNT_W-1:0]  cnt,
  output logic [CNT_W-1:0]  rem
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] fresh;
  logic [ACC_W-1:0] kept;

  // Kept separate from the merge logic: the top derives read from rem, and
  // read feeds back into the merge below.
  assign rem = xfer ? (cnt_q - w) : cnt_q;

  always_comb begin
    kept  = xfer ? (acc_q >> w) : acc_q;
    fresh = {{(ACC_W-BYTE_W){1'b0}}, datain & byte_mask(b)} << rem;
    acc_d = kept;
    cnt_d = rem;
    if (read) begin
      // Bits above rem are zero, so OR is a clean append.
      acc_d = kept | fresh;
      cnt_d = rem + b;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign pix_lsb = acc_q[PIX_W-1:0];
  assign cnt     = cnt_q;

endmodule

// File: rtl/lcd_pixel_unpacker.sv
// ----------------------------------------------------------------------------
// lcd_pixel_unpacker
//   Pops packed bytes from a show-ahead byte FIFO and re-serialises them into
//   one 3-bit pixel per transfer on a valid/stall stream, using the same
//   LSB-first packing as the LCD pixel formatter (3-bit colour, 4-bit STN
//   mono, 8-bit mono).
//
//   Build option: define LCD_UNPACK_CNT_EN to add the pixcnt output, a 16-bit
//   wrapping count of transferred pixels cleared by reset and flush.
//
//   Ports:
//     clk        in   sole clock, rising edge
//     reset      in   synchronous active-high reset
//     flush      in   synchronous discard of residual bits; re-samples mode
//     LcdBW      in   1 = mono, 0 = colour (sampled only on reset/flush)
//     LcdMono8   in   mono only: 1 = 8 pixels/byte, 0 = 4 pixels/byte
//     datain     in   FIFO head byte, valid whenever empty = 0
//     empty      in   FIFO empty
//     read       out  pop the FIFO head this cycle
//     greypixel  out  current pixel
//     valid      out  greypixel is meaningful
//     stall      in   downstream not accepting; transfer = valid && !stall
//     pixcnt     out  transferred-pixel count (LCD_UNPACK_CNT_EN only)
// ----------------------------------------------------------------------------
module lcd_pixel_unpacker
  import lcd_fmt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              LcdBW,
  input  logic              LcdMono8,
  input  logic [BYTE_W-1:0] datain,
  input  logic              empty,
  output logic              read,
  output logic [PIX_W-1:0]  greypixel,
  output logic              valid,
  input  logic              stall
`ifdef LCD_UNPACK_CNT_EN
  ,
  output logic [15:0]       pixcnt
`endif
);

  lcd_pixmode_t     mode_q, mode_d;
  pix_bits_t        pb;
  logic             clear;
  logic             xfer;
  logic [PIX_W-1:0] pix_lsb;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rem;

  assign clear  = reset | flush;

  // Mode pins are only honoured on reset/flush so a mid-frame change cannot
  // re-interpret bits already buffered.
  assign mode_d = decode_mode(LcdBW, LcdMono8);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mode_q <= mode_d;
    end
  end

  assign pb = pix_bits(mode_q);

  // valid depends on registered state only; stall reaches read, never valid.
  assign valid = (cnt >= pb.w);
  assign xfer  = valid & ~stall;

  // Pop whenever what survives this cycle cannot form a whole pixel. This
  // lets the refill overlap the transfer of the last whole pixel.
  assign read  = ~empty & (rem < pb.w) & ~reset & ~flush;

  lcd_unpack_bitbuf u_bitbuf (
    .clk     (clk),
    .clear   (clear),
    .w       (pb.w),
    .b       (pb.b),
    .xfer    (xfer),
    .read    (read),
    .datain  (datain),
    .pix_lsb (pix_lsb),
    .cnt     (cnt),
    .rem     (rem)
  );

  assign greypixel = format_pixel(mode_q, pix_lsb);

`ifdef LCD_UNPACK_CNT_EN
  logic [15:0] pixcnt_q, pixcnt_d;

  assign pixcnt_d = xfer ? (pixcnt_q + 16'd1) : pixcnt_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pixcnt_q <= '0;
    end else begin
      pixcnt_q <= pixcnt_d;
    end
  end

  assign pixcnt = pixcnt_q;
`endif

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// ----------------------------------------------------------------------------
// tb_lcd_pixel_unpacker
//   Directed and randomized bench for lcd_pixel_unpacker. The reference model
//   keeps the FIFO as a byte queue and the unconsumed stream as a queue of
//   bits: each popped byte appends its useful bits LSB-first, each transfer
//   removes one pixel's worth from the front.
// ----------------------------------------------------------------------------
module tb_lcd_pixel_unpacker;

  logic       clk = 1'b0;
  logic       reset, flush, LcdBW, LcdMono8, empty, stall;
  logic [7:0] datain;
  logic       read, valid;
  logic [2:0] greypixel;
`ifdef LCD_UNPACK_CNT_EN
  logic [15:0] pixcnt;
`endif

  lcd_pixel_unpacker dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .LcdBW     (LcdBW),
    .LcdMono8  (LcdMono8),
    .datain    (datain),
    .empty     (empty),
    .read      (read),
    .greypixel (greypixel),
    .valid     (valid),
    .stall     (stall)
`ifdef LCD_UNPACK_CNT_EN
    ,
    .pixcnt    (pixcnt)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  byte unsigned fifo[$];
  logic        bq[$];
  logic [2:0]  got[$];
  int          mmode;        // 0 colour, 1 mono4, 2 mono8
  int          nreads;
  int          xfer_total;
  logic [15:0] pix_model;
  logic        req_rst, req_bw, req_m8;
  logic        s_valid, s_read;
  logic [2:0]  s_pix;
  logic [15:0] s_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pin_mode(input logic bw, input logic m8);
    return (!bw) ? 0 : (m8 ? 2 : 1);
  endfunction

  // One clock cycle: drive at negedge, sample and check just after, then let
  // the rising edge update the model.
  task automatic cyc(input logic st, input logic fl);
    int           w;
    logic         xf;
    int           rem;
    logic         exp_read;
    logic [2:0]   exp_pix;
    byte unsigned by;
    @(negedge clk);
    reset    = req_rst;
    LcdBW    = req_bw;
    LcdMono8 = req_m8;
    stall    = st;
    flush    = fl;
    empty    = (fifo.size() == 0);
    datain   = empty ? 8'h00 : fifo[0];
    #1;
    s_valid = valid;
    s_read  = read;
    s_pix   = greypixel;
`ifdef LCD_UNPACK_CNT_EN
    s_cnt = pixcnt;
    chk("pixcnt", pixcnt, pix_model);
`else
    s_cnt = 16'h0;
`endif
    w  = (mmode == 0) ? 3 : 1;
    xf = (bq.size() >= w) && !st;
    chk("valid", {15'd0, valid}, {15'd0, (bq.size() >= w)});
    rem = bq.size() - (xf ? w : 0);
    exp_read = !empty && (rem < w) && !fl && !reset;
    chk("read", {15'd0, read}, {15'd0, exp_read});
    if (xf) begin
      exp_pix = (mmode == 0) ? {bq[2], bq[1], bq[0]} : {3{bq[0]}};
      chk("pixel", {13'd0, greypixel}, {13'd0, exp_pix});
      got.push_back(greypixel);
      for (int i = 0; i < w; i++) void'(bq.pop_front());
      pix_model++;
      xfer_total++;
    end
    @(posedge clk);
    if (read === 1'b1 && fifo.size() > 0) begin
      by = fifo.pop_front();
      nreads++;
      for (int i = 0; i < ((mmode == 1) ? 4 : 8); i++) bq.push_back(by[i]);
    end
    if (fl || reset) begin
      bq.delete();
      mmode     = pin_mode(LcdBW, LcdMono8);
      pix_model = 16'd0;
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    chk("pix_count", got.size()[15:0], n[15:0]);
  endtask

  task automatic set_mode(input logic bw, input logic m8);
    req_bw = bw;
    req_m8 = m8;
    cyc(1'b0, 1'b1);
    got.delete();
    nreads = 0;
  endtask

  logic [2:0] exp_m8[8];
  logic [2:0] exp_fl[8];
  int         r0;
  int         x0;

  initial begin
    reset = 1'b1; flush = 1'b0; LcdBW = 1'b0; LcdMono8 = 1'b0;
    datain = 8'h00; empty = 1'b1; stall = 1'b0;
    req_rst = 1'b1; req_bw = 1'b0; req_m8 = 1'b0;
    mmode = 0; nreads = 0; xfer_total = 0; pix_model = 16'd0;
    s_cnt = 16'd0;
    exp_m8 = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7, 3'd0, 3'd7};
    exp_fl = '{3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7};

    // Reset state
    fifo.push_back(8'h55);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rst_read", {15'd0, s_read}, 16'd0);
    chk("rst_valid", {15'd0, s_valid}, 16'd0);
    chk("rst_pix", {13'd0, s_pix}, 16'd0);
    fifo.delete();
    req_rst = 1'b0;
    cyc(1'b0, 1'b0);

    // Colour: 0x88 C6 FA -> pixels 0..7 with three pops
    got.delete(); nreads = 0;
    fifo.push_back(8'h88); fifo.push_back(8'hC6); fifo.push_back(8'hFA);
    run_until(8, 30);
    for (int i = 0; i < 8; i++) chk("col_pix", {13'd0, got[i]}, i[15:0]);
    chk("col_reads", nreads[15:0], 16'd3);
    cyc(1'b0, 1'b0);
    chk("col_idle", {15'd0, s_valid}, 16'd0);

    // Mono8: 0xA5
    set_mode(1'b1, 1'b1);
    fifo.push_back(8'hA5);
    run_until(8, 20);
    for (int i = 0; i < 8; i++) chk("m8_pix", {13'd0, got[i]}, {13'd0, exp_m8[i]});
    cyc(1'b0, 1'b0);
    chk("m8_idle", {15'd0, s_valid}, 16'd0);

    // Mono4: 0xF3, high nibble ignored
    set_mode(1'b1, 1'b0);
    fifo.push_back(8'hF3);
    run_until(4, 20);
    chk("m4_p0", {13'd0, got[0]}, 16'd7);
    chk("m4_p1", {13'd0, got[1]}, 16'd7);
    chk("m4_p2", {13'd0, got[2]}, 16'd0);
    chk("m4_p3", {13'd0, got[3]}, 16'd0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("m4_total", got.size()[15:0], 16'd4);

    // Colour with a 5-cycle stall after pixel 1
    set_mode(1'b0, 1'b0);
    fifo.push_back(8'h88); fifo.push_back(8'hC6); fifo.push_back(8'hFA);
    run_until(2, 20);
    r0 = nreads;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      chk("stall_vld", {15'd0, s_valid}, 16'd1);
      chk("stall_pix", {13'd0, s_pix}, 16'd2);
    end
    chk("stall_reads", {15'd0, (nreads - r0) <= 1}, 16'd1);
    run_until(8, 30);
    for (int i = 2; i < 8; i++) chk("stall_seq", {13'd0, got[i]}, i[15:0]);

    // FIFO runs dry with a partial pixel buffered
    set_mode(1'b0, 1'b0);
    fifo.push_back(8'h88);
    run_until(2, 20);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0);
      chk("dry_vld", {15'd0, s_valid}, 16'd0);
    end
    chk("dry_cnt", got.size()[15:0], 16'd2);
    fifo.push_back(8'hC6);
    run_until(3, 20);
    chk("dry_resume", {13'd0, got[2]}, 16'd2);

    // Flush mid-byte with LcdBW toggled: colour -> mono8
    set_mode(1'b0, 1'b0);
    fifo.push_back(8'h88); fifo.push_back(8'hC6);
    run_until(1, 20);
    req_bw = 1'b1; req_m8 = 1'b1;
    cyc(1'b0, 1'b1);
    chk("fl_read", {15'd0, s_read}, 16'd0);
    got.delete();
    cyc(1'b0, 1'b0);
    chk("fl_valid", {15'd0, s_valid}, 16'd0);
`ifdef LCD_UNPACK_CNT_EN
    chk("fl_pixcnt", s_cnt, 16'd0);
`endif
    run_until(8, 20);
    for (int i = 0; i < 8; i++) chk("fl_pix", {13'd0, got[i]}, {13'd0, exp_fl[i]});

    // Randomized segments; pins wiggle mid-segment and must be ignored
    for (int seg = 0; seg < 12; seg++) begin
      set_mode($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      for (int k = 0; k < 150; k++) begin
        if (fifo.size() < 3 && $urandom_range(0, 3) != 0) fifo.push_back(8'($urandom));
        if ($urandom_range(0, 15) == 0) req_bw = ~req_bw;
        if ($urandom_range(0, 15) == 0) req_m8 = ~req_m8;
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0);
      end
    end

`ifdef LCD_UNPACK_CNT_EN
    // 65536 colour transfers wrap pixcnt back to zero
    set_mode(1'b0, 1'b0);
    x0 = xfer_total;
    for (int k = 0; k < 70000 && (xfer_total - x0) < 65536; k++) begin
      if (fifo.size() < 4) fifo.push_back(8'($urandom));
      cyc(1'b0, 1'b0);
    end
    chk("wrap_n", 16'((xfer_total - x0) == 65536), 16'd1);
    cyc(1'b1, 1'b0);
    chk("wrap_pixcnt", s_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_unpacker.md
# lcd_pixel_unpacker

Read-side counterpart of the LCD pixel formatter. It pops packed bytes from a show-ahead byte FIFO (read/empty) and re-serialises them into one 3-bit pixel per transfer on a valid/stall stream. It uses the same bit packing the formatter writes, and sits between the frame FIFO and the panel driver or the readback/compare path. It supports 3-bit colour, 4-bit STN mono and 8-bit mono packing.

## Interface
- No parameters; byte width 8 and pixel width 3 are fixed constants in the shared package.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of residual bits; re-samples mode.
- LcdBW  in  1  1 = mono, 0 = colour; wired from reg7.
- LcdMono8  in  1  mono only: 1 = 8 pixels/byte, 0 = 4 pixels/byte (low nibble).
- datain  in  8  FIFO head word, valid whenever empty=0.
- empty  in  1  FIFO empty.
- read  out  1  pop FIFO head this cycle.
- greypixel  out  3  current pixel.
- valid  out  1  greypixel is meaningful.
- stall  in  1  downstream not accepting; a transfer occurs when valid && !stall.

## Operation
- Bit stream packing is LSB-first. Pixel k occupies stream bits [3k+2:3k], and byte j carries stream bits [8j+7:8j].
  - Colour: 8 pixels per 3 bytes; pixels straddle byte boundaries.
  - Mono8: pixel k is byte bit k.
  - Mono4: pixel k is byte bit k for k<4; bits [7:4] are discarded.
- Mode register mode_q ∈ {MODE_COLOR3, MODE_MONO4, MODE_MONO8}.
  - Loaded from LcdBW/LcdMono8 in every cycle that reset or flush is high.
  - Ignored pins otherwise; a mid-frame pin change has no effect until the next flush.
- Derived widths: W = 3 (colour) or 1 (mono). B = 8 (colour, mono8) or 4 (mono4).
- Bit buffer acc[9:0] with count cnt[3:0], range 0..10. cnt is the state; the block holds no other FSM.
  - EMPTY: cnt=0.
  - PARTIAL: 0<cnt<W.
  - READY: cnt≥W.
- Per-cycle rules:
  - valid = (cnt ≥ W).
  - xfer = valid && !stall.
  - rem = cnt − (xfer ? W : 0).
  - read = !empty && (rem < W) && !reset && !flush.
- Register update:
  - acc ← (xfer ? acc >> W : acc) | (read ? (datain & Bmask) << rem : 0).
  - cnt ← rem + (read ? B : 0).
- Output formatting:
  - Colour: greypixel = acc[2:0].
  - Mono: greypixel = {3{acc[0]}}, i.e. 3'b111 or 3'b000. The formatter consumes only bit 0, so a round trip is exact.
- Bits of acc above cnt are always 0.
- stall freezes acc, cnt, greypixel and valid. read can still fire if rem<W, so PARTIAL can fill while stalled.
- FIFO empty with cnt in PARTIAL: hold the residual bits, valid=0, and resume when empty=0. No bits are lost and none are duplicated.
- reset or flush: acc←0, cnt←0, read=0 in that cycle. Residual bits are discarded and the FIFO is not touched.

## Timing
- Reset values: read=0, valid=0, greypixel=0; (pixcnt=0).
- Latency: with cnt=0, read=1 in cycle N makes valid=1 in cycle N+1.
- Throughput: one pixel per cycle sustained in all modes whenever the FIFO stays non-empty and stall=0. A refill overlaps the transfer of the last whole pixel.
- valid and greypixel are registered-state functions only; there is no combinational path from stall.
- read depends combinationally on stall, empty and the state.
- Reset and flush both take effect at the first rising edge they are seen high.

## Configuration
- LCD_UNPACK_CNT_EN defined: adds output pixcnt[15:0].
  - Increments on every xfer and wraps 0xFFFF→0.
  - Cleared by reset and flush.
- LCD_UNPACK_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package lcd_fmt_pkg holds:
  - mode enum lcd_pixmode_t (MODE_COLOR3, MODE_MONO4, MODE_MONO8);
  - constants PIX_W=3 and BYTE_W=8;
  - function pix_bits(mode) returning W and B.
- The formatter also switches to this package.
- One natural sub-module, lcd_unpack_bitbuf, holds acc/cnt and the shift/merge datapath given W, B, xfer and read.
- The top level holds mode_q, the handshake equations and the optional counter.

## Test plan
- Colour, FIFO holds 0x88,0xC6,0xFA, stall=0 → greypixel 0,1,2,3,4,5,6,7 on 8 consecutive valid cycles, with exactly 3 read pulses.
- Mono8, byte 0xA5 → 7,0,7,0,0,7,0,7 then valid=0. Mono4, byte 0xF3 → 7,7,0,0, with the high nibble ignored.
- Colour stream, stall=1 for 5 cycles after pixel 1 → greypixel=2 and valid=1 held throughout. Sequence continues 2..7 with no loss; read fires at most once during the stall.
- Colour, only 0x88 present, then empty for 4 cycles → pixels 0,1, then valid=0 with cnt=2. After pushing 0xC6, the next pixel is 2.
- flush (or reset) asserted mid-byte with LcdBW toggled → next cycle valid=0, read=0, residual discarded; the new mode decodes the next byte. pixcnt=0 if LCD_UNPACK_CNT_EN.
- 65536 colour pixels with LCD_UNPACK_CNT_EN → pixcnt wraps to 0.
